// File: rtl/mac_filter.sv
// mac_filter
// ----------
// Ethernet destination-address filter for a narrow beat-serial stream.
// Each frame arrives as one contiguous run of axiiv-high beats, N bits per
// beat, MSB-first, byte 0 first: destination MAC, source MAC, then the
// ethertype and payload. Frames addressed to MY_MAC or to broadcast have
// their source address captured and everything from the ethertype onward
// forwarded with one cycle of latency. Frames addressed elsewhere are
// swallowed and flagged with a one-cycle drop pulse.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   axiid[N-1:0]   input beat
//   axiiv          input beat valid; any low cycle ends the current frame
//   axiov          forwarded beat valid
//   axiod[N-1:0]   forwarded beat, zero whenever axiov is low
//   src_mac[47:0]  source address of the last accepted frame
//   src_mac_valid  src_mac holds a complete address
//   drop           one-cycle pulse when a frame fails the address check
//
// Parameters
//   N       beat width in bits: 1, 2, 4 or 8
//   MY_MAC  station address accepted as destination

module mac_filter #(
  parameter int          N      = 2,
  parameter logic [47:0] MY_MAC = 48'h69695A065491
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic [47:0]  src_mac,
  output logic         src_mac_valid,
  output logic         drop
);

  // Beats per MAC field and the narrowest counter that can hold BEATS-1.
  localparam int          BEATS = 48 / N;
  localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    PASS,
    DROP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [47-N:0]   dst_q;
  logic            armed_q;
  logic [47:0]     srcMac_q;
  logic            srcValid_q;
  logic            axiov_q;
  logic [N-1:0]    axiod_q;
  logic            drop_q;

  logic [47:0]     fullDst;
  logic            dstMatch;

  // The destination is collected in a left-shifting register that starts
  // from zero, so after BEATS-1 beats the first beat sits in the top N bits
  // of the finished address. The last beat is compared straight off the
  // input rather than waiting a cycle to be stored.
  assign fullDst  = {dst_q, axiid};
  assign dstMatch = (fullDst == MY_MAC) || (fullDst == BCAST);

  // All state and every output live in this one block so the outputs come
  // straight from flops. drop, axiov and axiod default low each cycle and
  // are raised only by the state that owns them, which keeps the drop
  // pulse to a single cycle and axiod at zero outside forwarded beats.
  // armed_q is cleared by reset and set by any axiiv-low cycle; IDLE will
  // not start a frame without it, so a frame that was in flight when reset
  // released is ignored until the line goes quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dst_q      <= '0;
      armed_q    <= 1'b0;
      srcMac_q   <= '0;
      srcValid_q <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q  <= 1'b0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      if (!axiiv) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        dst_q   <= '0;
        armed_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (armed_q) begin
              dst_q   <= {dst_q[47-2*N:0], axiid};
              cnt_q   <= CW'(1);
              state_q <= DST;
            end
          end
          DST: begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              dst_q <= '0;
              if (dstMatch) begin
                state_q    <= SRC;
                srcValid_q <= 1'b0;
              end else begin
                state_q <= DROP;
                drop_q  <= 1'b1;
              end
            end else begin
              dst_q <= {dst_q[47-2*N:0], axiid};
              cnt_q <= cnt_q + CW'(1);
            end
          end
          SRC: begin
            srcMac_q <= {srcMac_q[47-N:0], axiid};
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              state_q    <= PASS;
              srcValid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PASS: begin
            axiov_q <= 1'b1;
            axiod_q <= axiid;
          end
          DROP: begin
            state_q <= DROP;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
          end
        endcase
      end
    end
  end

  assign axiov         = axiov_q;
  assign axiod         = axiod_q;
  assign src_mac       = srcMac_q;
  assign src_mac_valid = srcValid_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_mac_filter.sv
// tb_mac_filter
// -------------
// Directed bench for mac_filter. A table of whole frames is streamed into an
// N=2 instance, each with hand-computed expectations for drop, forwarded
// data, capture timing and the source address. Hand-written sequences cover
// an N=8 instance, and reset asserted mid-frame.

module tb_mac_filter;

  localparam logic [47:0] MY = 48'h69695A065491;
  localparam logic [47:0] BC = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  axiid;
  logic        axiiv;
  logic        axiov;
  logic [1:0]  axiod;
  logic [47:0] srcMac;
  logic        srcMacValid;
  logic        drop;

  logic [7:0]  axiid8;
  logic        axiiv8;
  logic        axiov8;
  logic [7:0]  axiod8;
  logic [47:0] srcMac8;
  logic        srcMacValid8;
  logic        drop8;

  mac_filter #(.N(2), .MY_MAC(MY)) dut2 (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
    .axiov(axiov), .axiod(axiod), .src_mac(srcMac),
    .src_mac_valid(srcMacValid), .drop(drop)
  );

  mac_filter #(.N(8), .MY_MAC(MY)) dut8 (
    .clk(clk), .rst(rst), .axiid(axiid8), .axiiv(axiiv8),
    .axiov(axiov8), .axiod(axiod8), .src_mac(srcMac8),
    .src_mac_valid(srcMacValid8), .drop(drop8)
  );

  // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One frame record: what to send and what the outputs must show.
  // Index fields count N=2 beats from the start of the frame; -1 means
  // "never happens". expSrc is skipped when chkSrc is 0.
  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [23:0] payload;
    int          beats;
    int          gap;
    logic        chkSrc;
    int          expDropCnt;
    int          expDropIdx;
    int          expFwdCnt;
    logic [23:0] expFwdData;
    logic [47:0] expSrc;
    logic        expValid;
    int          expRiseIdx;
    int          expFirstFwd;
    int          expLastFwd;
  } vec_t;

  localparam int NUM = 8;
  vec_t tbl [NUM];

  int vecCount = 0;
  int missCount = 0;

  int          mDropCnt;
  int          mDropIdx;
  int          mFwdCnt;
  logic [23:0] mFwdData;
  int          mRiseIdx;
  int          mFirstFwd;
  int          mLastFwd;
  int          mLeak;
  logic        prevValid;

  // Single comparison point: every check bumps vecCount, every mismatch
  // bumps missCount and prints one line.
  task automatic checkVal(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Record what the N=2 outputs show for the effect of beat idx.
  task automatic sampleN2(input int idx);
    if (drop) begin
      mDropCnt++;
      if (mDropIdx < 0) mDropIdx = idx;
    end
    if (axiov) begin
      mFwdCnt++;
      mFwdData = {mFwdData[21:0], axiod};
      if (mFirstFwd < 0) mFirstFwd = idx;
      mLastFwd = idx;
    end else if (axiod !== 2'b00) begin
      mLeak++;
    end
    if (srcMacValid && !prevValid && mRiseIdx < 0) mRiseIdx = idx;
    prevValid = srcMacValid;
  endtask

  // Stream one frame into the N=2 instance followed by v.gap idle cycles.
  // A beat is driven 1 unit after a rising edge; the falling edge one
  // cycle later shows the registered result of that beat.
  task automatic applyStimulus(input vec_t v);
    logic [119:0] fb;
    fb        = {v.dst, v.src, v.payload};
    mDropCnt  = 0;
    mDropIdx  = -1;
    mFwdCnt   = 0;
    mFwdData  = '0;
    mRiseIdx  = -1;
    mFirstFwd = -1;
    mLastFwd  = -1;
    mLeak     = 0;
    prevValid = srcMacValid;
    for (int k = 0; k < v.beats + v.gap; k++) begin
      @(posedge clk);
      #1;
      if (k < v.beats) begin
        axiiv = 1'b1;
        axiid = fb[119-2*k -: 2];
      end else begin
        axiiv = 1'b0;
        axiid = 2'b00;
      end
      @(negedge clk);
      if (k > 0) sampleN2(k - 1);
    end
  endtask

  // Compare the recorded frame behaviour against the table entry.
  task automatic checkOutput(input vec_t v, input int i);
    checkVal($sformatf("v%0d dropCnt", i), 64'(mDropCnt), 64'(v.expDropCnt));
    checkVal($sformatf("v%0d dropIdx", i), 64'(mDropIdx), 64'(v.expDropIdx));
    checkVal($sformatf("v%0d fwdCnt", i), 64'(mFwdCnt), 64'(v.expFwdCnt));
    checkVal($sformatf("v%0d fwdData", i), 64'(mFwdData), 64'(v.expFwdData));
    checkVal($sformatf("v%0d srcValid", i), 64'(srcMacValid), 64'(v.expValid));
    checkVal($sformatf("v%0d validRise", i), 64'(mRiseIdx), 64'(v.expRiseIdx));
    checkVal($sformatf("v%0d firstFwd", i), 64'(mFirstFwd), 64'(v.expFirstFwd));
    checkVal($sformatf("v%0d lastFwd", i), 64'(mLastFwd), 64'(v.expLastFwd));
    checkVal($sformatf("v%0d axiodLeak", i), 64'(mLeak), 64'd0);
    if (v.chkSrc) checkVal($sformatf("v%0d srcMac", i), 64'(srcMac), 64'(v.expSrc));
  endtask

  initial begin
    logic [119:0] fb;
    logic [119:0] fb2;
    int           rise8;
    int           first8;
    int           last8;
    int           cnt8;
    logic [23:0]  data8;
    int           post;

    // Accepted frame: 08 00 AA payload, forwarded starting at beat 48.
    tbl[0] = '{MY, 48'h001122334455, 24'h0800AA, 60, 3, 1'b1,
               0, -1, 12, 24'h0800AA, 48'h001122334455, 1'b1, 47, 48, 59};
    // Broadcast with ARP ethertype 08 06.
    tbl[1] = '{BC, 48'h0A0B0C0D0E0F, 24'h080600, 60, 3, 1'b1,
               0, -1, 12, 24'h080600, 48'h0A0B0C0D0E0F, 1'b1, 47, 48, 59};
    // Off-by-one destination: drop after beat 23, nothing forwarded,
    // source address of the previous frame kept.
    tbl[2] = '{48'h69695A065490, 48'h111111111111, 24'h0800AA, 60, 3, 1'b1,
               1, 23, 0, 24'h000000, 48'h0A0B0C0D0E0F, 1'b1, -1, -1, -1};
    // Frame cut inside the destination after 10 beats, one idle cycle.
    tbl[3] = '{MY, 48'h222222222222, 24'h000000, 10, 1, 1'b1,
               0, -1, 0, 24'h000000, 48'h0A0B0C0D0E0F, 1'b1, -1, -1, -1};
    // Starts on the cycle right after the cut frame.
    tbl[4] = '{MY, 48'h665544332211, 24'h123456, 60, 3, 1'b1,
               0, -1, 12, 24'h123456, 48'h665544332211, 1'b1, 47, 48, 59};
    // Broadcast cut inside the source field: valid cleared, stays clear.
    tbl[5] = '{BC, 48'hABCDEF012345, 24'h000000, 36, 3, 1'b0,
               0, -1, 0, 24'h000000, 48'h0, 1'b0, -1, -1, -1};
    // Cut after two payload bytes: exactly 8 beats forwarded.
    tbl[6] = '{MY, 48'h001122334455, 24'h0800AA, 56, 3, 1'b1,
               0, -1, 8, 24'h000800, 48'h001122334455, 1'b1, 47, 48, 55};
    // First clean frame after the mid-frame reset sequence.
    tbl[7] = '{MY, 48'h0A0B0C0D0E0F, 24'h080600, 60, 3, 1'b1,
               0, -1, 12, 24'h080600, 48'h0A0B0C0D0E0F, 1'b1, 47, 48, 59};

    rst    = 1'b0;
    axiiv  = 1'b0;
    axiid  = 2'b00;
    axiiv8 = 1'b0;
    axiid8 = 8'h00;

    // Reset raised before any clock edge must clear outputs on its own.
    #2 rst = 1'b1;
    #1;
    checkVal("rst axiov", 64'(axiov), 64'd0);
    checkVal("rst axiod", 64'(axiod), 64'd0);
    checkVal("rst srcMac", 64'(srcMac), 64'd0);
    checkVal("rst srcValid", 64'(srcMacValid), 64'd0);
    checkVal("rst drop", 64'(drop), 64'd0);
    checkVal("rst srcValid8", 64'(srcMacValid8), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // N=8: 15 byte beats, source captured after beat 11, bytes 08 00 AA
    // forwarded at beats 12..14.
    fb     = {MY, 48'h001122334455, 24'h0800AA};
    rise8  = -1;
    first8 = -1;
    last8  = -1;
    cnt8   = 0;
    data8  = '0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      #1;
      if (k < 15) begin
        axiiv8 = 1'b1;
        axiid8 = fb[119-8*k -: 8];
      end else begin
        axiiv8 = 1'b0;
        axiid8 = 8'h00;
      end
      @(negedge clk);
      if (k > 0) begin
        if (axiov8) begin
          cnt8++;
          data8 = {data8[15:0], axiod8};
          if (first8 < 0) first8 = k - 1;
          last8 = k - 1;
        end
        if (srcMacValid8 && rise8 < 0) rise8 = k - 1;
      end
    end
    checkVal("n8 validRise", 64'(rise8), 64'd11);
    checkVal("n8 firstFwd", 64'(first8), 64'd12);
    checkVal("n8 lastFwd", 64'(last8), 64'd14);
    checkVal("n8 fwdCnt", 64'(cnt8), 64'd3);
    checkVal("n8 fwdData", 64'(data8), 64'h0800AA);
    checkVal("n8 srcMac", 64'(srcMac8), 64'h001122334455);

    for (int i = 0; i < NUM - 1; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i);
    end

    // Reset in the middle of PASS, between clock edges.
    fb = {MY, 48'h001122334455, 24'h0800AA};
    for (int k = 0; k < 52; k++) begin
      @(posedge clk);
      #1;
      axiiv = 1'b1;
      axiid = fb[119-2*k -: 2];
    end
    @(negedge clk);
    checkVal("midrst pre axiov", 64'(axiov), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkVal("midrst axiov", 64'(axiov), 64'd0);
    checkVal("midrst axiod", 64'(axiod), 64'd0);
    checkVal("midrst srcValid", 64'(srcMacValid), 64'd0);
    checkVal("midrst srcMac", 64'(srcMac), 64'd0);
    @(posedge clk);
    #1;
    axiid = fb[119-2*52 -: 2];
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Still inside the interrupted run of axiiv: a complete well-formed
    // frame follows without a gap and must be ignored entirely.
    fb2  = {MY, 48'h0A0B0C0D0E0F, 24'h080600};
    post = 0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      axiiv = 1'b1;
      axiid = fb2[119-2*k -: 2];
      @(negedge clk);
      if (axiov || drop) post++;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      axiiv = 1'b0;
      axiid = 2'b00;
      @(negedge clk);
      if (axiov || drop) post++;
    end
    checkVal("postrst ignored", 64'(post), 64'd0);
    checkVal("postrst srcValid", 64'(srcMacValid), 64'd0);
    checkVal("postrst srcMac", 64'(srcMac), 64'd0);

    applyStimulus(tbl[NUM-1]);
    checkOutput(tbl[NUM-1], NUM - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/mac_filter.md
MAC_FILTER -- requirements
Module: mac_filter

Interface
REQ-001 SHALL have parameter N, default 2, meaning beat width in bits; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter MY_MAC, default 48'h69695A065491, meaning the station address accepted as destination.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port axiid  input  N  frame beat: destination MAC first, then source MAC, then ethertype and payload; MSB-first, byte 0 first.
REQ-006 SHALL have port axiiv  input  1  beat valid; a frame is one contiguous run of axiiv high, and any low cycle ends the frame.
REQ-007 SHALL have port axiov  output  1  forwarded beat valid.
REQ-008 SHALL have port axiod  output  N  forwarded beat: ethertype onward, same bit order as input.
REQ-009 SHALL have port src_mac  output  48  captured source address of the last accepted frame.
REQ-010 SHALL have port src_mac_valid  output  1  src_mac holds a complete address for the current or most recent accepted frame.
REQ-011 SHALL have port drop  output  1  one-cycle pulse when a frame is rejected on destination address.

Function
REQ-012 SHALL define BEATS = 48/N as the beat count of each MAC field, with a counter just wide enough to hold BEATS-1.
REQ-013 SHALL implement states IDLE, DST, SRC, PASS, DROP.
REQ-014 IDLE: an axiiv-high cycle SHALL store the beat as destination bits [47:48-N], set the counter to 1 and move to DST.
REQ-015 DST: each valid beat SHALL fill the next lower N destination bits.
REQ-016 DST, on beat BEATS-1: the complete address {stored bits, axiid} SHALL be compared with MY_MAC and with 48'hFFFFFFFFFFFF.
REQ-017 On a match the block SHALL go to SRC, clear src_mac_valid and reset the counter.
REQ-018 On no match the block SHALL go to DROP and assert drop for the following cycle only.
REQ-019 SRC: each valid beat SHALL shift into src_mac MSB-first.
REQ-020 SRC, on beat BEATS-1: the block SHALL go to PASS and set src_mac_valid on the next edge.
REQ-021 PASS: every cycle SHALL register axiov <= axiiv and axiod <= axiid, giving exactly 1-cycle latency and no beat dropped, duplicated or reordered.
REQ-022 DROP: axiov SHALL remain 0 until the frame ends.
REQ-023 In any state, axiiv low SHALL return the block to IDLE and clear the counter and partial destination; axiov SHALL be 0 on the next cycle.
REQ-024 A frame that ends in DST SHALL produce no drop pulse and no output.
REQ-025 A frame that ends in SRC SHALL leave src_mac_valid at 0.
REQ-026 axiov SHALL never be high outside PASS-forwarded beats; axiod SHALL be 0 whenever axiov is 0.
REQ-027 A new frame starting the cycle after axiiv falls SHALL be handled normally, since IDLE is entered on the low cycle.
REQ-028 src_mac and src_mac_valid SHALL hold their values across IDLE until a later frame passes the destination check.

Reset
REQ-029 rst high SHALL immediately, independent of clk, force state IDLE, counter 0, axiov 0, axiod 0, src_mac 0, src_mac_valid 0 and drop 0.
REQ-030 Deassertion of rst mid-frame SHALL cause the remaining beats of that frame to be ignored until axiiv has been low for at least one cycle.

Verification
REQ-031 N=2, dest 69:69:5A:06:54:91, src 00:11:22:33:44:55, then 08 00 AA -> drop stays 0; src_mac=48'h001122334455 and src_mac_valid=1 one cycle after beat 47; axiod forwards 0,0,2,0,0,0,0,0,... one cycle late; axiov falls one cycle after axiiv.
REQ-032 Dest FF:FF:FF:FF:FF:FF, ethertype 08 06 -> frame accepted; the downstream ethertype stage sees 16'h0806.
REQ-033 Dest 69:69:5A:06:54:90 -> drop=1 for exactly the cycle after beat 23; axiov stays 0 for the whole frame; src_mac is unchanged from the prior frame.
REQ-034 axiiv falls after 10 beats, then a valid frame starts on the next cycle -> no drop pulse; the second frame is accepted normally.
REQ-035 rst asserted mid-PASS between clock edges -> axiov, axiod and src_mac_valid read 0 before the next clk edge; beats after rst release are not forwarded until an axiiv-low gap occurs.
REQ-036 N=8 with the scenario of REQ-031 -> src_mac captured after 12 beats; ethertype bytes 08, 00 forwarded with 1-cycle latency.
